// File: rtl/mem_port_arbiter.sv
// Shares one single-port, word-addressed memory bus between the ag32 fetch and data ports.
// Define ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           state_reg, state_next;
  logic             owner_i_reg, owner_i_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             m_req_reg, m_req_next;
  logic             m_we_reg, m_we_next;
  logic [31:0]      m_addr_reg, m_addr_next;
  logic [31:0]      m_wdata_reg, m_wdata_next;
  logic [3:0]       m_wstrb_reg, m_wstrb_next;
  logic             i_rvalid_reg, i_rvalid_next;
  logic             i_err_reg, i_err_next;
  logic [31:0]      i_rdata_reg, i_rdata_next;
  logic             d_rvalid_reg, d_rvalid_next;
  logic             d_err_reg, d_err_next;
  logic [31:0]      d_rdata_reg, d_rdata_next;
  logic             grant_i, grant_d;
  logic             timeout_hit;
  logic             rsp_fire, rsp_err;
  logic [31:0]      rsp_data;
  logic             unused_addr_bits;

  // Byte-offset bits are discarded: the bus is word addressed.
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

`ifdef ARB_RR_EN
  logic last_i_reg;

  assign grant_i = (state_reg == IDLE) && i_req && (!d_req || !last_i_reg);
  assign grant_d = (state_reg == IDLE) && d_req && (!i_req || last_i_reg);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_i_reg <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_i_reg <= grant_i;
    end
  end
`else
  assign grant_i = (state_reg == IDLE) && i_req && !d_req;
  assign grant_d = (state_reg == IDLE) && d_req;
`endif

  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == TIMEOUT_CNT);

  always_comb begin
    state_next    = state_reg;
    owner_i_next  = owner_i_reg;
    cnt_next      = cnt_reg;
    m_req_next    = m_req_reg;
    m_we_next     = m_we_reg;
    m_addr_next   = m_addr_reg;
    m_wdata_next  = m_wdata_reg;
    m_wstrb_next  = m_wstrb_reg;
    i_rvalid_next = 1'b0;
    i_err_next    = 1'b0;
    i_rdata_next  = i_rdata_reg;
    d_rvalid_next = 1'b0;
    d_err_next    = 1'b0;
    d_rdata_next  = d_rdata_reg;
    rsp_fire      = 1'b0;
    rsp_err       = 1'b0;
    rsp_data      = '0;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next   = ISSUE;
          owner_i_next = 1'b0;
          m_req_next   = 1'b1;
          m_we_next    = d_we;
          m_addr_next  = {d_addr[31:2], 2'b00};
          m_wdata_next = d_wdata;
          m_wstrb_next = d_wstrb;
        end else if (grant_i) begin
          state_next   = ISSUE;
          owner_i_next = 1'b1;
          m_req_next   = 1'b1;
          m_we_next    = 1'b0;
          m_addr_next  = {i_addr[31:2], 2'b00};
          m_wdata_next = '0;
          m_wstrb_next = '0;
        end
      end
      ISSUE: begin
        if (m_gnt) begin
          state_next = WAIT;
          m_req_next = 1'b0;
          cnt_next   = '0;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        // A real response beats a timeout landing in the same cycle.
        if (m_rvalid) begin
          rsp_fire = 1'b1;
          rsp_err  = m_err;
          rsp_data = m_we_reg ? '0 : m_rdata;
        end else if (timeout_hit) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end
        if (rsp_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rsp_fire) begin
      if (owner_i_reg) begin
        i_rvalid_next = 1'b1;
        i_err_next    = rsp_err;
        i_rdata_next  = rsp_data;
      end else begin
        d_rvalid_next = 1'b1;
        d_err_next    = rsp_err;
        d_rdata_next  = rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      owner_i_reg  <= 1'b0;
      cnt_reg      <= '0;
      m_req_reg    <= 1'b0;
      m_we_reg     <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      m_wstrb_reg  <= '0;
      i_rvalid_reg <= 1'b0;
      i_err_reg    <= 1'b0;
      i_rdata_reg  <= '0;
      d_rvalid_reg <= 1'b0;
      d_err_reg    <= 1'b0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      owner_i_reg  <= owner_i_next;
      cnt_reg      <= cnt_next;
      m_req_reg    <= m_req_next;
      m_we_reg     <= m_we_next;
      m_addr_reg   <= m_addr_next;
      m_wdata_reg  <= m_wdata_next;
      m_wstrb_reg  <= m_wstrb_next;
      i_rvalid_reg <= i_rvalid_next;
      i_err_reg    <= i_err_next;
      i_rdata_reg  <= i_rdata_next;
      d_rvalid_reg <= d_rvalid_next;
      d_err_reg    <= d_err_next;
      d_rdata_reg  <= d_rdata_next;
    end
  end

  assign i_gnt    = grant_i;
  assign d_gnt    = grant_d;
  assign i_rvalid = i_rvalid_reg;
  assign i_rdata  = i_rdata_reg;
  assign i_err    = i_err_reg;
  assign d_rvalid = d_rvalid_reg;
  assign d_rdata  = d_rdata_reg;
  assign d_err    = d_err_reg;
  assign m_req    = m_req_reg;
  assign m_we     = m_we_reg;
  assign m_addr   = m_addr_reg;
  assign m_wdata  = m_wdata_reg;
  assign m_wstrb  = m_wstrb_reg;
  assign busy     = (state_reg != IDLE);
endmodule
